multicycle_ctrl_fsm: RTL and testbench

- Sequencing control unit for the multicycle 16-bit RISC datapath; replaces purely combinational opcode decode with a per-instruction state machine.
- Latches the opcode on fetch and steps through FETCH, DECODE, EXEC, MEM and WB.
- Issues one-cycle datapath enables per state.
- Stalls on instruction/data memory ready handshakes.
- Counts retired instructions.
- Parametrised in instruction width, opcode width and counter width.

---
 rtl/multicycle_ctrl_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// issuing one-cycle datapath enables and counting retired instructions.
module multicycle_ctrl_fsm #(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               branch_taken,
    output logic               imem_rd,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               alu_src,
    output logic [2:0]         alu_op,
    output logic               ext_op,
    output logic               dmem_rd,
    output logic               dmem_wr,
    output logic               l_type,
    output logic               sv,
    output logic               reg_wr,
    output logic               rf_dst,
    output logic [1:0]         wb_sel,
    output logic [2:0]         state,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [3:0] OP_AND  = 4'h0, OP_ADD = 4'h1, OP_SUB  = 4'h2, OP_ADDI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4, OP_LW  = 4'h5, OP_LB   = 4'h6, OP_SW   = 4'h7;
    localparam logic [3:0] OP_BGT  = 4'h8, OP_BLT = 4'h9, OP_BEQ  = 4'hA, OP_BNE  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC, OP_CALL = 4'hD, OP_RET = 4'hE, OP_SV   = 4'hF;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q, state_d;
    logic [OPC_W-1:0]  opc_q, opc_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  retired_q;
    logic              retire;

    logic [3:0] op4;
    logic       opc_ext;
    logic       is_load, is_store, is_branch;

    assign op4       = opc_q[3:0];
    // Opcodes beyond the 16 defined ones only exist when OPC_W is wider than 4.
    assign opc_ext   = (OPC_W > 4) ? |(opc_q >> 4) : 1'b0;
    assign is_load   = (op4 == OP_LW) || (op4 == OP_LB);
    assign is_store  = (op4 == OP_SW) || (op4 == OP_SV);
    assign is_branch = (op4 == OP_BGT) || (op4 == OP_BLT) || (op4 == OP_BEQ) || (op4 == OP_BNE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opc_q     <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            illegal_q <= illegal_d;
            if (retire) retired_q <= retired_q + CNT_ONE;
        end
    end

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        imem_rd   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        alu_src   = 1'b0;
        alu_op    = 3'b000;
        ext_op    = 1'b0;
        dmem_rd   = 1'b0;
        dmem_wr   = 1'b0;
        l_type    = 1'b0;
        sv        = 1'b0;
        reg_wr    = 1'b0;
        rf_dst    = 1'b0;
        wb_sel    = 2'd0;

        unique case (state_q)
            S_FETCH: begin
                if (run) begin
                    imem_rd = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        opc_d    = instr[INSTR_W-1 -: OPC_W];
                        state_d  = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (opc_ext) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    case (op4)
                        OP_JMP: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd2;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end
                        OP_CALL: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd2;
                            reg_wr   = 1'b1;
                            rf_dst   = 1'b1;
                            wb_sel   = 2'd2;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end
                        OP_RET: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd3;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end
                        default: state_d = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                case (op4)
                    OP_AND:  alu_op = 3'b000;
                    OP_ADD:  alu_op = 3'b001;
                    OP_SUB:  alu_op = 3'b010;
                    OP_ADDI: begin alu_src = 1'b1; alu_op = 3'b001; ext_op = 1'b1; end
                    OP_ANDI: begin alu_src = 1'b1; alu_op = 3'b000; end
                    OP_LW, OP_LB, OP_SW: begin
                        alu_src = 1'b1;
                        alu_op  = 3'b001;
                        ext_op  = 1'b1;
                    end
                    OP_BGT, OP_BLT, OP_BEQ, OP_BNE: begin
                        alu_op = 3'b010;
                        ext_op = 1'b1;
                    end
                    default: ;
                endcase
                if (is_branch) begin
                    pc_write = branch_taken;
                    pc_src   = 2'd1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (is_load) begin
                    dmem_rd = 1'b1;
                    l_type  = (op4 == OP_LW);
                end else begin
                    dmem_wr = 1'b1;
                    sv      = (op4 == OP_SV);
                end
                if (dmem_ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_wr  = 1'b1;
                wb_sel  = is_load ? 2'd1 : 2'd0;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed table-driven bench for multicycle_ctrl_fsm, plus a 5-bit-opcode /
// 4-bit-counter instance for the illegal-opcode trap and counter wrap.
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic [2:0]  state;
        logic        imem_rd;
        logic        ir_write;
        logic        pc_write;
        logic [1:0]  pc_src;
        logic        alu_src;
        logic [2:0]  alu_op;
        logic        ext_op;
        logic        dmem_rd;
        logic        dmem_wr;
        logic        l_type;
        logic        sv;
        logic        reg_wr;
        logic        rf_dst;
        logic [1:0]  wb_sel;
        logic        illegal;
        logic [31:0] retired;
    } outs_t;

    typedef struct {
        string       name;
        logic        run;
        logic [15:0] instr;
        logic        imem_ready;
        logic        dmem_ready;
        logic        branch_taken;
        outs_t       exp;
    } vec_t;

    logic clk;
    logic rst_n, run, imem_ready, dmem_ready, branch_taken;
    logic [15:0] instr;
    logic imem_rd, ir_write, pc_write, alu_src, ext_op, dmem_rd, dmem_wr, l_type, sv;
    logic reg_wr, rf_dst, illegal;
    logic [1:0] pc_src, wb_sel;
    logic [2:0] alu_op, state;
    logic [31:0] retired;

    logic rst2_n, run2, imem_ready2, dmem_ready2, branch_taken2;
    logic [15:0] instr2;
    logic x_imem_rd, x_ir_write, x_pc_write, x_alu_src, x_ext_op, x_dmem_rd, x_dmem_wr;
    logic x_l_type, x_sv, x_reg_wr, x_rf_dst, x_illegal;
    logic [1:0] x_pc_src, x_wb_sel;
    logic [2:0] x_alu_op, x_state;
    logic [3:0] x_retired;

    outs_t act, act5;
    int nchk = 0;
    int nfail = 0;
    vec_t vecs[$];

    multicycle_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr(instr),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
        .imem_rd(imem_rd), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .dmem_rd(dmem_rd),
        .dmem_wr(dmem_wr), .l_type(l_type), .sv(sv), .reg_wr(reg_wr), .rf_dst(rf_dst),
        .wb_sel(wb_sel), .state(state), .illegal(illegal), .retired(retired)
    );

    multicycle_ctrl_fsm #(.INSTR_W(16), .OPC_W(5), .CNT_W(4)) dut5 (
        .clk(clk), .rst_n(rst2_n), .run(run2), .instr(instr2),
        .imem_ready(imem_ready2), .dmem_ready(dmem_ready2), .branch_taken(branch_taken2),
        .imem_rd(x_imem_rd), .ir_write(x_ir_write), .pc_write(x_pc_write), .pc_src(x_pc_src),
        .alu_src(x_alu_src), .alu_op(x_alu_op), .ext_op(x_ext_op), .dmem_rd(x_dmem_rd),
        .dmem_wr(x_dmem_wr), .l_type(x_l_type), .sv(x_sv), .reg_wr(x_reg_wr), .rf_dst(x_rf_dst),
        .wb_sel(x_wb_sel), .state(x_state), .illegal(x_illegal), .retired(x_retired)
    );

    assign act  = {state, imem_rd, ir_write, pc_write, pc_src, alu_src, alu_op, ext_op,
                   dmem_rd, dmem_wr, l_type, sv, reg_wr, rf_dst, wb_sel, illegal, retired};
    assign act5 = {x_state, x_imem_rd, x_ir_write, x_pc_write, x_pc_src, x_alu_src, x_alu_op,
                   x_ext_op, x_dmem_rd, x_dmem_wr, x_l_type, x_sv, x_reg_wr, x_rf_dst,
                   x_wb_sel, x_illegal, 28'd0, x_retired};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic outs_t base(input logic [2:0] s, input int r);
        outs_t e;
        e = '0;
        e.state   = s;
        e.retired = r;
        return e;
    endfunction

    function automatic outs_t fx(input int r);
        outs_t e;
        e = base(3'd0, r);
        e.imem_rd  = 1'b1;
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        return e;
    endfunction

    task automatic add(input string nm, input logic r, input logic [15:0] ins,
                       input logic ir, input logic dr, input logic bt, input outs_t e);
        vec_t v;
        v.name = nm; v.run = r; v.instr = ins;
        v.imem_ready = ir; v.dmem_ready = dr; v.branch_taken = bt; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input outs_t a, input outs_t e);
        nchk++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, a, e);
        end
    endtask

    initial begin
        outs_t e;

        // ADD, zero wait: FETCH, DECODE, EXEC, WB
        add("add_fetch", 1, 16'h1234, 1, 0, 0, fx(0));
        add("add_decode", 1, 16'h0000, 1, 1, 0, base(3'd1, 0));
        e = base(3'd2, 0); e.alu_op = 3'b001;
        add("add_exec", 1, 16'h0000, 0, 0, 0, e);
        e = base(3'd4, 0); e.reg_wr = 1'b1;
        add("add_wb", 1, 16'h0000, 0, 0, 0, e);
        // LW with three data-memory wait cycles; dmem_ready early is ignored
        add("lw_fetch", 1, 16'h5678, 1, 0, 0, fx(1));
        add("lw_decode", 1, 16'h0000, 1, 1, 0, base(3'd1, 1));
        e = base(3'd2, 1); e.alu_src = 1'b1; e.alu_op = 3'b001; e.ext_op = 1'b1;
        add("lw_exec", 1, 16'h0000, 0, 1, 0, e);
        e = base(3'd3, 1); e.dmem_rd = 1'b1; e.l_type = 1'b1;
        add("lw_mem_w1", 1, 16'h0000, 0, 0, 0, e);
        add("lw_mem_w2", 1, 16'h0000, 0, 0, 0, e);
        add("lw_mem_w3", 1, 16'h0000, 0, 0, 0, e);
        add("lw_mem_done", 1, 16'h0000, 0, 1, 0, e);
        e = base(3'd4, 1); e.reg_wr = 1'b1; e.wb_sel = 2'd1;
        add("lw_wb", 1, 16'h0000, 0, 0, 0, e);
        // BEQ taken after an instruction-memory wait, then BNE not taken
        e = base(3'd0, 2); e.imem_rd = 1'b1;
        add("beq_fetch_wait", 1, 16'hA000, 0, 0, 0, e);
        add("beq_fetch", 1, 16'hA000, 1, 0, 0, fx(2));
        add("beq_decode", 1, 16'h0000, 0, 0, 1, base(3'd1, 2));
        e = base(3'd2, 2); e.alu_op = 3'b010; e.ext_op = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'd1;
        add("beq_exec", 1, 16'h0000, 0, 0, 1, e);
        add("bne_fetch", 1, 16'hB000, 1, 0, 0, fx(3));
        add("bne_decode", 1, 16'h0000, 0, 0, 1, base(3'd1, 3));
        e = base(3'd2, 3); e.alu_op = 3'b010; e.ext_op = 1'b1; e.pc_src = 2'd1;
        add("bne_exec", 1, 16'h0000, 0, 0, 0, e);
        // CALL then RET
        add("call_fetch", 1, 16'hD000, 1, 0, 0, fx(4));
        e = base(3'd1, 4); e.pc_write = 1'b1; e.pc_src = 2'd2; e.reg_wr = 1'b1;
        e.rf_dst = 1'b1; e.wb_sel = 2'd2;
        add("call_decode", 1, 16'h0000, 0, 0, 0, e);
        add("ret_fetch", 1, 16'hE000, 1, 0, 0, fx(5));
        e = base(3'd1, 5); e.pc_write = 1'b1; e.pc_src = 2'd3;
        add("ret_decode", 1, 16'h0000, 0, 0, 0, e);
        // SW zero wait
        add("sw_fetch", 1, 16'h7000, 1, 0, 0, fx(6));
        add("sw_decode", 1, 16'h0000, 0, 0, 0, base(3'd1, 6));
        e = base(3'd2, 6); e.alu_src = 1'b1; e.alu_op = 3'b001; e.ext_op = 1'b1;
        add("sw_exec", 1, 16'h0000, 0, 0, 0, e);
        e = base(3'd3, 6); e.dmem_wr = 1'b1;
        add("sw_mem", 1, 16'h0000, 0, 1, 0, e);
        // ANDI with run dropped mid-instruction: completes, then idles
        add("andi_fetch", 1, 16'h4000, 1, 0, 0, fx(7));
        add("andi_decode", 0, 16'h0000, 1, 0, 0, base(3'd1, 7));
        e = base(3'd2, 7); e.alu_src = 1'b1;
        add("andi_exec", 0, 16'h0000, 1, 0, 0, e);
        e = base(3'd4, 7); e.reg_wr = 1'b1;
        add("andi_wb", 0, 16'h0000, 1, 0, 0, e);
        add("idle_1", 0, 16'h1000, 1, 1, 0, base(3'd0, 8));
        add("idle_2", 0, 16'h1000, 1, 1, 0, base(3'd0, 8));
        // LB: byte load, l_type low
        add("lb_fetch", 1, 16'h6000, 1, 0, 0, fx(8));
        add("lb_decode", 1, 16'h0000, 0, 0, 0, base(3'd1, 8));
        e = base(3'd2, 8); e.alu_src = 1'b1; e.alu_op = 3'b001; e.ext_op = 1'b1;
        add("lb_exec", 1, 16'h0000, 0, 0, 0, e);
        e = base(3'd3, 8); e.dmem_rd = 1'b1;
        add("lb_mem", 1, 16'h0000, 0, 1, 0, e);
        e = base(3'd4, 8); e.reg_wr = 1'b1; e.wb_sel = 2'd1;
        add("lb_wb", 1, 16'h0000, 0, 0, 0, e);
        // SV stalled in MEM; reset follows
        add("sv_fetch", 1, 16'hF000, 1, 0, 0, fx(9));
        add("sv_decode", 1, 16'h0000, 0, 0, 0, base(3'd1, 9));
        add("sv_exec", 1, 16'h0000, 0, 0, 0, base(3'd2, 9));
        e = base(3'd3, 9); e.dmem_wr = 1'b1; e.sv = 1'b1;
        add("sv_mem_wait", 1, 16'h0000, 0, 0, 0, e);

        rst_n = 1'b0; run = 1'b0; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
        branch_taken = 1'b0;
        rst2_n = 1'b0; run2 = 1'b0; instr2 = '0; imem_ready2 = 1'b0; dmem_ready2 = 1'b0;
        branch_taken2 = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", act, base(3'd0, 0));
        chk("reset_state_w5", act5, base(3'd0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        rst2_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            run = vecs[i].run;
            instr = vecs[i].instr;
            imem_ready = vecs[i].imem_ready;
            dmem_ready = vecs[i].dmem_ready;
            branch_taken = vecs[i].branch_taken;
            #1;
            chk(vecs[i].name, act, vecs[i].exp);
        end

        // Asynchronous reset while SV waits in MEM, ahead of the next clock edge
        #2;
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        chk("sv_async_reset", act, base(3'd0, 0));

        // Illegal 5-bit opcode 0x10 traps until reset
        @(negedge clk);
        run2 = 1'b1; instr2 = 16'h8000; imem_ready2 = 1'b1;
        #1;
        chk("ill_fetch", act5, fx(0));
        @(negedge clk);
        #1;
        chk("ill_decode", act5, base(3'd1, 0));
        e = base(3'd7, 0); e.illegal = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dmem_ready2 = 1'b1; branch_taken2 = 1'b1;
            #1;
            chk("ill_trap", act5, e);
        end
        #2;
        rst2_n = 1'b0;
        run2 = 1'b0; dmem_ready2 = 1'b0; branch_taken2 = 1'b0;
        #1;
        chk("ill_reset", act5, base(3'd0, 0));

        // 16 back-to-back JMPs wrap the 4-bit retired counter
        @(negedge clk);
        rst2_n = 1'b1;
        run2 = 1'b1; instr2 = 16'h6000; imem_ready2 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk("wrap_fetch", act5, fx(k));
            @(negedge clk);
            #1;
            e = base(3'd1, k); e.pc_write = 1'b1; e.pc_src = 2'd2;
            chk("wrap_jmp_decode", act5, e);
        end
        @(negedge clk);
        run2 = 1'b0;
        #1;
        chk("wrap_to_zero", act5, base(3'd0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
